// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// 8N1 UART receiver feeding a show-ahead FIFO; byte visible the cycle after its stop sample.
// No line backpressure: a byte arriving at a full FIFO without a same-cycle pop is dropped with overrun_o.

module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_dat,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_pop_dat,
    output logic                         o_vld,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_overrun
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_full;
    logic             w_pop;
    logic             w_push_ok;

    assign w_full    = (r_level == LVL_W'(DEPTH));
    assign w_pop     = i_pop & (r_level != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = i_push & (~w_full | w_pop);
    assign o_overrun = i_push & w_full & ~w_pop;
    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_vld     = (r_level != '0);
    assign o_level   = r_level;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + LVL_W'(w_push_ok) - LVL_W'(w_pop);
        end
    end
endmodule

module uart_rx_fifo #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUDRATE   = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              ser_rx,
    output logic [7:0]                        rdata_o,
    output logic                              rvalid_o,
    input  logic                              rready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o,
    output logic                              frame_err_o,
    output logic                              overrun_o,
    output logic                              busy_o
);
    localparam int DIV   = CLK_FREQ / BAUDRATE;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);

    if (DIV < 4) begin : g_div_check
        $error("uart_rx_fifo: CLK_FREQ/BAUDRATE must be at least 4");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("uart_rx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             w_ser_s;
    logic             w_push;
    logic             w_frame_err;

    assign w_ser_s = r_sync2;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_sync1   <= ser_rx;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + 1'b1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_push        = 1'b0;
        w_frame_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_ser_s) w_state_nxt = S_START;
            end
            S_START: begin
                // Recheck mid start bit so short glitches never start a frame.
                if (r_cnt == CNT_W'(HALF - 1)) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = w_ser_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_W'(DIV - 1)) begin
                    w_cnt_nxt              = '0;
                    w_shift_nxt[r_bit_idx] = w_ser_s;
                    if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
                    else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_W'(DIV - 1)) begin
                    w_cnt_nxt = '0;
                    if (w_ser_s) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A line held low reports once, then waits for idle.
                w_cnt_nxt = '0;
                if (w_ser_s) w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (clk_i),
        .i_rst_n    (rst_ni),
        .i_push     (w_push),
        .i_push_dat (r_shift_push_dat()),
        .i_pop      (rready_i),
        .o_pop_dat  (rdata_o),
        .o_vld      (rvalid_o),
        .o_level    (level_o),
        .o_overrun  (overrun_o)
    );

    function automatic logic [7:0] r_shift_push_dat();
        return r_shift;
    endfunction

    assign frame_err_o = w_frame_err;
    assign busy_o      = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_fifo at DIV=10, HALF=5, FIFO_DEPTH=4.
module tb_uart_rx_fifo;
    localparam int CLK_FREQ   = 1_000_000;
    localparam int BAUDRATE   = 100_000;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV        = 10;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       ser_rx;
    logic       rready_i;
    logic [7:0] rdata_o;
    logic       rvalid_o;
    logic [2:0] level_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    uart_rx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUDRATE   (BAUDRATE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .ser_rx      (ser_rx),
        .rdata_o     (rdata_o),
        .rvalid_o    (rvalid_o),
        .rready_i    (rready_i),
        .level_o     (level_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;
    int n_fe  = 0;
    int n_ov  = 0;
    bit both_seen = 1'b0;

    always @(negedge clk_i) begin
        if (frame_err_o) n_fe <= n_fe + 1;
        if (overrun_o)   n_ov <= n_ov + 1;
        if (frame_err_o && overrun_o) both_seen <= 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         is_send;
        logic [7:0] dat;
        bit         pop_at_push;
        int         exp_level;
        logic [7:0] exp_head;
        int         exp_ov;
    } vec_t;

    vec_t vecs [18];

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        ser_rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            tick(DIV);
        end
        ser_rx = stop;
        tick(DIV);
    endtask

    task automatic pop_one();
        rready_i = 1'b1;
        tick(1);
        rready_i = 1'b0;
    endtask

    initial begin
        int cyc;
        int fe0;
        int ov0;
        logic [7:0] c3;

        vecs[0]  = '{1'b1, 8'h01, 1'b0, 1, 8'h01, 0};
        vecs[1]  = '{1'b1, 8'h02, 1'b0, 2, 8'h01, 0};
        vecs[2]  = '{1'b1, 8'h03, 1'b0, 3, 8'h01, 0};
        vecs[3]  = '{1'b1, 8'h04, 1'b0, 4, 8'h01, 0};
        vecs[4]  = '{1'b1, 8'h05, 1'b0, 4, 8'h01, 1};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 3, 8'h01, 1};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 2, 8'h02, 1};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1, 8'h03, 1};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 0, 8'h04, 1};
        vecs[9]  = '{1'b1, 8'h01, 1'b0, 1, 8'h01, 1};
        vecs[10] = '{1'b1, 8'h02, 1'b0, 2, 8'h01, 1};
        vecs[11] = '{1'b1, 8'h03, 1'b0, 3, 8'h01, 1};
        vecs[12] = '{1'b1, 8'h04, 1'b0, 4, 8'h01, 1};
        vecs[13] = '{1'b1, 8'h05, 1'b1, 4, 8'h02, 1};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 3, 8'h02, 1};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 2, 8'h03, 1};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 1, 8'h04, 1};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 0, 8'h05, 1};

        rst_ni   = 1'b0;
        ser_rx   = 1'b1;
        rready_i = 1'b0;
        tick(3);
        chk("reset rdata",  32'(rdata_o),  32'h0);
        chk("reset rvalid", 32'(rvalid_o), 32'h0);
        chk("reset level",  32'(level_o),  32'h0);
        chk("reset busy",   32'(busy_o),   32'h0);
        chk("reset ferr",   32'(frame_err_o), 32'h0);
        chk("reset ovr",    32'(overrun_o),   32'h0);
        rst_ni = 1'b1;
        tick(5);

        // First byte: measure fall-to-valid latency.
        cyc = 0;
        fork
            send_byte(8'h68, 1'b1);
            begin
                while (cyc < 200) begin
                    tick(1);
                    cyc++;
                    if (rvalid_o) break;
                end
            end
        join
        chk("latency", 32'(cyc), 32'd98);
        chk("h rdata", 32'(rdata_o), 32'h68);
        chk("h level", 32'(level_o), 32'd1);
        chk("h ferr count", 32'(n_fe), 32'd0);
        chk("h ovr count",  32'(n_ov), 32'd0);
        pop_one();
        chk("h drained", 32'(rvalid_o), 32'h0);

        // Short glitch on the idle line.
        ser_rx = 1'b0;
        tick(3);
        chk("glitch busy up", 32'(busy_o), 32'h1);
        ser_rx = 1'b1;
        tick(8);
        chk("glitch busy down", 32'(busy_o), 32'h0);
        chk("glitch rvalid", 32'(rvalid_o), 32'h0);
        chk("glitch pulses", 32'(n_fe + n_ov), 32'd0);

        // Framing error followed by a held-low line.
        send_byte(8'h55, 1'b0);
        chk("break ferr once", 32'(n_fe), 32'd1);
        chk("break level", 32'(level_o), 32'd0);
        tick(40);
        chk("break still busy", 32'(busy_o), 32'h1);
        chk("break ferr held", 32'(n_fe), 32'd1);
        ser_rx = 1'b1;
        tick(2);
        chk("break exit wait", 32'(busy_o), 32'h1);
        tick(2);
        chk("break idle", 32'(busy_o), 32'h0);
        send_byte(8'hA5, 1'b1);
        chk("a5 rdata", 32'(rdata_o), 32'hA5);
        chk("a5 level", 32'(level_o), 32'd1);
        chk("a5 ferr", 32'(n_fe), 32'd1);
        pop_one();

        fe0 = n_fe;
        ov0 = n_ov;
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].is_send) begin
                if (vecs[i].pop_at_push) begin
                    fork
                        send_byte(vecs[i].dat, 1'b1);
                        begin
                            tick(97);
                            rready_i = 1'b1;
                            tick(1);
                            rready_i = 1'b0;
                        end
                    join
                end else begin
                    send_byte(vecs[i].dat, 1'b1);
                end
                chk($sformatf("vec%0d level", i), 32'(level_o), 32'(vecs[i].exp_level));
                chk($sformatf("vec%0d head", i),  32'(rdata_o), 32'(vecs[i].exp_head));
                chk($sformatf("vec%0d rvalid", i), 32'(rvalid_o), 32'(vecs[i].exp_level != 0));
                chk($sformatf("vec%0d overruns", i), 32'(n_ov - ov0), 32'(vecs[i].exp_ov));
            end else begin
                chk($sformatf("vec%0d head", i), 32'(rdata_o), 32'(vecs[i].exp_head));
                pop_one();
                chk($sformatf("vec%0d level", i), 32'(level_o), 32'(vecs[i].exp_level));
            end
        end
        chk("table ferr", 32'(n_fe - fe0), 32'd0);

        // Reset in the middle of bit 3 of 0xC3 with a byte already queued.
        send_byte(8'h5A, 1'b1);
        chk("pre-reset level", 32'(level_o), 32'd1);
        fe0 = n_fe;
        ov0 = n_ov;
        c3 = 8'hC3;
        ser_rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 3; i++) begin
            ser_rx = c3[i];
            tick(DIV);
        end
        ser_rx = c3[3];
        tick(5);
        chk("midframe busy", 32'(busy_o), 32'h1);
        rst_ni = 1'b0;
        ser_rx = 1'b1;
        tick(1);
        chk("rst busy",   32'(busy_o),   32'h0);
        chk("rst rvalid", 32'(rvalid_o), 32'h0);
        chk("rst level",  32'(level_o),  32'h0);
        chk("rst rdata",  32'(rdata_o),  32'h0);
        rst_ni = 1'b1;
        tick(30);
        chk("post-rst level", 32'(level_o), 32'h0);
        chk("post-rst busy",  32'(busy_o),  32'h0);
        send_byte(8'h3C, 1'b1);
        chk("3c rdata", 32'(rdata_o), 32'h3C);
        chk("3c level", 32'(level_o), 32'd1);
        chk("rst pulses", 32'((n_fe - fe0) + (n_ov - ov0)), 32'd0);
        chk("pulses exclusive", 32'(both_seen), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
